// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with write-through bypass and a
// per-register pending scoreboard (set at issue, cleared at writeback or flush).
module regfile_sb #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 5,
    parameter int              NRD      = 2,
    parameter logic [XLEN-1:0] SP_RESET = 32'h00000500,
    parameter bit              BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  flush,
    output logic                  any_busy
);
    localparam int NREGS = 1 << ADDR_W;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    genvar gi;

    // One flop bank per register; x0 is reset to zero and never written.
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= (gi == 2) ? SP_RESET : '0;
                end else if (gi != 0 && wb_valid && wb_addr == ADDR_W'(gi)) begin
                    regs_q[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // Priority: flush clears, then issue sets, then writeback clears.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                pend_d[r] = 1'b0;
            end else if (iss_valid && iss_addr == ADDR_W'(r)) begin
                pend_d[r] = 1'b1;
            end else if (wb_valid && wb_addr == ADDR_W'(r)) begin
                pend_d[r] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign any_busy = |pend_q;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              hit;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
            // Forwarding only ever looks at writeback, never at issue.
            assign hit  = BYPASS && wb_valid && (wb_addr == addr);

            always_comb begin
                rd_data[gi*XLEN +: XLEN] = regs_q[addr];
                rd_busy[gi]              = pend_q[addr] && !hit;
                if (addr == '0) begin
                    rd_data[gi*XLEN +: XLEN] = '0;
                    rd_busy[gi]              = 1'b0;
                end else if (hit) begin
                    rd_data[gi*XLEN +: XLEN] = wb_data;
                end
            end
        end
    endgenerate

endmodule
